// File: rtl/modexp_ctrl.sv
// -----------------------------------------------------------------------------
// modexp_ctrl
//   Sequencer that computes X^E mod M by driving one Montgomery multiplier core
//   through its start/done handshake. The exponent is scanned left-to-right
//   (square-and-multiply) entirely in the Montgomery domain:
//     CONV : Xt = Mont(X, R^2)           A = R mod M
//     SQ   : A  = Mont(A, A)             (for every scanned exponent bit)
//     MUL  : A  = Mont(A, Xt)            (only when that bit is 1)
//     POST : result = Mont(A, 1)         (leave the Montgomery domain)
//   No modular arithmetic is done here; all of it goes through the core.
//
// Optional build macro:
//   MODEXP_SKIP_LZ_EN - start the scan at the most significant 1 of E instead
//                       of bit EW-1; E = 0 goes straight from CONV to POST.
//                       The result is identical in both builds.
//
// Ports:
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   start                one-cycle request, operands sampled in that cycle
//   in_x/in_e/in_m       base, exponent, odd modulus
//   in_r2/in_rmodm       R^2 mod M and R mod M, R = 2^WIDTH
//   result/done/busy     X^E mod M, one-cycle completion pulse, busy flag
//   mont_start           one-cycle call pulse to the core
//   mont_in_a/b/m        core operands (registered, stable during a call)
//   mont_result/done     core result and completion pulse
// -----------------------------------------------------------------------------
module modexp_ctrl #(
   parameter int WIDTH = 1024,
   parameter int EW    = 1024
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_x,
   input  logic [EW-1:0]    in_e,
   input  logic [WIDTH-1:0] in_m,
   input  logic [WIDTH-1:0] in_r2,
   input  logic [WIDTH-1:0] in_rmodm,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             mont_start,
   output logic [WIDTH-1:0] mont_in_a,
   output logic [WIDTH-1:0] mont_in_b,
   output logic [WIDTH-1:0] mont_in_m,
   input  logic [WIDTH-1:0] mont_result,
   input  logic             mont_done
);

   localparam int               IW      = (EW > 1) ? $clog2(EW) : 1;
   localparam logic [IW-1:0]    IDX_TOP = IW'(EW - 1);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CONV = 3'd1,
      ST_SQ   = 3'd2,
      ST_MUL  = 3'd3,
      ST_NEXT = 3'd4,
      ST_POST = 3'd5,
      ST_DONE = 3'd6
   } state_t;

   state_t           state_r;
   state_t           state_next_s;

   logic [WIDTH-1:0] x_r;
   logic [EW-1:0]    e_r;
   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] r2_r;
   logic [WIDTH-1:0] rmodm_r;
   logic [WIDTH-1:0] xt_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] result_r;
   logic [IW-1:0]    idx_r;
   logic             wait_r;
   logic             mont_start_r;
   logic             done_r;
   logic             busy_r;

   logic             call_state_s;
   logic             issue_s;
   logic             accept_s;
   logic [WIDTH-1:0] op_a_s;
   logic [WIDTH-1:0] op_b_s;
   logic [IW-1:0]    conv_idx_s;
   logic             conv_skip_s;

`ifdef MODEXP_SKIP_LZ_EN
   // Priority encoder: index of the most significant set bit (0 when v == 0).
   function automatic logic [IW-1:0] msb_index(input logic [EW-1:0] v);
      logic [IW-1:0] idx;
      idx = {IW{1'b0}};
      for (int i = 0; i < EW; i++) begin
         if (v[i]) begin
            idx = IW'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   assign conv_idx_s  = msb_index(e_r);
   assign conv_skip_s = (e_r == {EW{1'b0}});
`else
   assign conv_idx_s  = IDX_TOP;
   assign conv_skip_s = 1'b0;
`endif

   // Next-state logic plus the operand pair for the call owned by each state.
   always_comb begin
      state_next_s = state_r;
      op_a_s       = {WIDTH{1'b0}};
      op_b_s       = {WIDTH{1'b0}};
      call_state_s = (state_r == ST_CONV) || (state_r == ST_SQ) ||
                     (state_r == ST_MUL)  || (state_r == ST_POST);
      // A calling state first issues (wait_r low), then waits for mont_done;
      // a mont_done outside that waiting phase is ignored.
      issue_s      = call_state_s && !wait_r;
      accept_s     = call_state_s && wait_r && mont_done;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_CONV;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CONV: begin
            op_a_s = x_r;
            op_b_s = r2_r;
            if (accept_s) begin
               state_next_s = conv_skip_s ? ST_POST : ST_SQ;
            end else begin
               state_next_s = ST_CONV;
            end
         end
         ST_SQ: begin
            op_a_s = acc_r;
            op_b_s = acc_r;
            if (accept_s) begin
               state_next_s = e_r[idx_r] ? ST_MUL : ST_NEXT;
            end else begin
               state_next_s = ST_SQ;
            end
         end
         ST_MUL: begin
            op_a_s = acc_r;
            op_b_s = xt_r;
            if (accept_s) begin
               state_next_s = ST_NEXT;
            end else begin
               state_next_s = ST_MUL;
            end
         end
         ST_NEXT: begin
            if (idx_r == {IW{1'b0}}) begin
               state_next_s = ST_POST;
            end else begin
               state_next_s = ST_SQ;
            end
         end
         ST_POST: begin
            op_a_s = acc_r;
            op_b_s = ONE;
            if (accept_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_POST;
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Operand capture, core handshake, accumulator updates and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_r          <= {WIDTH{1'b0}};
         e_r          <= {EW{1'b0}};
         m_r          <= {WIDTH{1'b0}};
         r2_r         <= {WIDTH{1'b0}};
         rmodm_r      <= {WIDTH{1'b0}};
         xt_r         <= {WIDTH{1'b0}};
         acc_r        <= {WIDTH{1'b0}};
         a_r          <= {WIDTH{1'b0}};
         b_r          <= {WIDTH{1'b0}};
         result_r     <= {WIDTH{1'b0}};
         idx_r        <= {IW{1'b0}};
         wait_r       <= 1'b0;
         mont_start_r <= 1'b0;
         done_r       <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         // mont_start is a single-cycle pulse: issue_s is true for exactly
         // one cycle per call because wait_r rises on the same edge.
         mont_start_r <= issue_s;
         done_r       <= 1'b0;
         if (issue_s) begin
            a_r    <= op_a_s;
            b_r    <= op_b_s;
            wait_r <= 1'b1;
         end else if (accept_s) begin
            wait_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  x_r      <= in_x;
                  e_r      <= in_e;
                  m_r      <= in_m;
                  r2_r     <= in_r2;
                  rmodm_r  <= in_rmodm;
                  result_r <= {WIDTH{1'b0}};
                  busy_r   <= 1'b1;
               end
            end
            ST_CONV: begin
               if (accept_s) begin
                  xt_r  <= mont_result;
                  acc_r <= rmodm_r;      // Montgomery form of 1
                  idx_r <= conv_idx_s;
               end
            end
            ST_SQ, ST_MUL: begin
               if (accept_s) begin
                  acc_r <= mont_result;
               end
            end
            ST_NEXT: begin
               if (idx_r != {IW{1'b0}}) begin
                  idx_r <= idx_r - IW'(1'b1);
               end
            end
            ST_POST: begin
               if (accept_s) begin
                  result_r <= mont_result;
                  done_r   <= 1'b1;
               end
            end
            ST_DONE: begin
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign result     = result_r;
   assign done       = done_r;
   assign busy       = busy_r;
   assign mont_start = mont_start_r;
   assign mont_in_a  = a_r;
   assign mont_in_b  = b_r;
   assign mont_in_m  = m_r;

endmodule

// File: tb/tb_modexp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_modexp_ctrl
//   Directed bench for modexp_ctrl (WIDTH=16, EW=1024). A behavioural
//   Montgomery responder answers each core call with a*b*R^-1 mod M after a
//   programmable latency. A monitor compares the DUT every cycle against a
//   plain-arithmetic model (X^E mod M, expected call count, busy window,
//   operand stability); directed tests add hand-computed literals.
// -----------------------------------------------------------------------------
module tb_modexp_ctrl;

   localparam int TW = 16;
   localparam int TE = 1024;

`ifdef MODEXP_SKIP_LZ_EN
   localparam longint CALLS_E3 = 6;
   localparam longint CALLS_E2 = 5;
   localparam longint CALLS_E0 = 2;
   localparam longint CALLS_E4 = 6;
`else
   localparam longint CALLS_E3 = 1028;
   localparam longint CALLS_E2 = 1027;
   localparam longint CALLS_E0 = 1026;
   localparam longint CALLS_E4 = 1027;
`endif

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic [TW-1:0] in_x;
   logic [TE-1:0] in_e;
   logic [TW-1:0] in_m;
   logic [TW-1:0] in_r2;
   logic [TW-1:0] in_rmodm;
   logic [TW-1:0] result;
   logic          done;
   logic          busy;
   logic          mont_start;
   logic [TW-1:0] mont_in_a;
   logic [TW-1:0] mont_in_b;
   logic [TW-1:0] mont_in_m;
   logic [TW-1:0] mont_result;
   logic          mont_done;

   // responder
   logic          resp_done = 1'b0;
   logic          spur_done = 1'b0;
   logic [TW-1:0] resp_res  = '0;
   logic          pend      = 1'b0;
   int            cnt       = 0;
   logic [TW-1:0] ra = '0, rb = '0, rm = '0;
   int            lat       = 1;

   // model / monitor state
   int      n_checks = 0;
   int      n_fail   = 0;
   bit      exp_busy = 1'b0;
   bit      active   = 1'b0;
   bit      in_call  = 1'b0;
   logic [TW-1:0] call_a = '0, call_b = '0;
   longint  op_calls  = 0;
   longint  op_dones  = 0;
   longint  exp_res   = 0;
   longint  exp_ncall = 0;
   longint  cur_m     = 0;

   assign mont_done   = resp_done | spur_done;
   assign mont_result = resp_res;

   modexp_ctrl #(.WIDTH(TW), .EW(TE)) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r2(in_r2), .in_rmodm(in_rmodm),
      .result(result), .done(done), .busy(busy),
      .mont_start(mont_start), .mont_in_a(mont_in_a), .mont_in_b(mont_in_b),
      .mont_in_m(mont_in_m), .mont_result(mont_result), .mont_done(mont_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // a*b*R^-1 mod m with R = 2^TW, by plain arithmetic
   function automatic logic [TW-1:0] mont(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                          input logic [TW-1:0] m);
      longint mm, rmod, rinv, p;
      mm = longint'(m);
      if (mm == 0) return '0;
      rmod = (longint'(1) << TW) % mm;
      rinv = 0;
      for (longint i = 1; i < mm; i++) begin
         if ((rmod * i) % mm == 1) rinv = i;
      end
      p = ((longint'(a) * longint'(b)) % mm) * rinv % mm;
      return TW'(p);
   endfunction

   function automatic longint modpow(input longint x, input longint e, input longint m);
      longint r;
      r = 1 % m;
      for (longint i = 0; i < e; i++) r = (r * x) % m;
      return r;
   endfunction

   // number of core calls implied by the exponent
   function automatic longint model_calls(input longint e);
      longint pop, msb;
      pop = 0; msb = -1;
      for (int i = 0; i < 63; i++) begin
         if (e[i]) begin pop++; msb = i; end
      end
`ifdef MODEXP_SKIP_LZ_EN
      if (e == 0) return 2;
      return 1 + (msb + 1) + pop + 1;
`else
      return 1 + TE + pop + 1;
`endif
   endfunction

   // Behavioural Montgomery core: answers each call after 'lat' cycles.
   always @(posedge clk) begin
      resp_done <= 1'b0;
      if (mont_start) begin
         pend <= 1'b1;
         cnt  <= lat;
         ra   <= mont_in_a;
         rb   <= mont_in_b;
         rm   <= mont_in_m;
      end else if (pend) begin
         if (cnt <= 1) begin
            resp_done <= 1'b1;
            resp_res  <= mont(ra, rb, rm);
            pend      <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   // Per-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            check("rst_result", 64'(result), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_mont_start", 64'(mont_start), 64'd0);
            exp_busy = 1'b0;
            active   = 1'b0;
            in_call  = 1'b0;
         end else begin
            check("busy", 64'(busy), 64'(exp_busy));
            if (mont_start) begin
               check("mont_start_overlap", 64'(in_call), 64'd0);
               check("mont_start_idle", 64'(exp_busy), 64'd1);
               in_call = 1'b1;
               call_a  = mont_in_a;
               call_b  = mont_in_b;
               op_calls++;
            end else if (in_call) begin
               check("mont_in_a_stable", 64'(mont_in_a), 64'(call_a));
               check("mont_in_b_stable", 64'(mont_in_b), 64'(call_b));
            end
            if (exp_busy) check("mont_in_m", 64'(mont_in_m), 64'(cur_m));
            if (mont_done) in_call = 1'b0;
            if (done) begin
               check("done_when_active", 64'(active), 64'd1);
               check("result_model", 64'(result), 64'(exp_res));
               check("calls_model", 64'(op_calls), 64'(exp_ncall));
               op_dones++;
               exp_busy = 1'b0;
               active   = 1'b0;
            end else if (start && !exp_busy) begin
               exp_res   = modpow(longint'(in_x), longint'(in_e[62:0]), longint'(in_m));
               exp_ncall = model_calls(longint'(in_e[62:0]));
               cur_m     = longint'(in_m);
               exp_busy  = 1'b1;
               active    = 1'b1;
               op_calls  = 0;
               op_dones  = 0;
            end
         end
      end
   end

   task automatic drive_start(input longint x, input longint e, input longint m);
      longint rmod;
      rmod = (longint'(1) << TW) % m;
      @(posedge clk); #1;
      in_x     = TW'(x);
      in_e     = '0;
      in_e[62:0] = e[62:0];
      in_m     = TW'(m);
      in_rmodm = TW'(rmod);
      in_r2    = TW'((rmod * rmod) % m);
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      // scramble inputs: the DUT must work from its captured copies
      in_x     = 16'h0bad;
      in_e[5:0] = 6'h3f;
      in_m     = 16'h0007;
      in_r2    = 16'h1234;
      in_rmodm = 16'h4321;
   endtask

   task automatic run_op(input string tag, input longint x, input longint e, input longint m,
                         input longint lit_res, input longint lit_calls, input bit spam);
      bit got;
      drive_start(x, e, m);
      got = 1'b0;
      for (int k = 0; k < 60000; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            got = 1'b1;
            break;
         end
         if (spam && (k % 50 == 7)) begin
            start = 1'b1;
            in_x  = TW'(k);
         end
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 64'(got), 64'd1);
      check({tag, "_result"}, 64'(result), 64'(lit_res));
      check({tag, "_calls"}, 64'(op_calls), 64'(lit_calls));
      @(posedge clk); #1;
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check({tag, "_done_width"}, 64'(done), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_held"}, 64'(result), 64'(lit_res));
      check({tag, "_one_done"}, 64'(op_dones), 64'd1);
   endtask

   initial begin
      bit seen;
      resetn = 1'b1;
      start = 1'b0; in_x = '0; in_e = '0; in_m = '0; in_r2 = '0; in_rmodm = '0;
      #2 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_result", 64'(result), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      resetn = 1'b1;

      lat = 1;
      run_op("x2e3", 2, 3, 13, 8, CALLS_E3, 1'b0);
      lat = 5;
      run_op("x5e2", 5, 2, 13, 12, CALLS_E2, 1'b0);
      lat = 1;
      run_op("x7e0", 7, 0, 13, 1, CALLS_E0, 1'b0);

      // spurious core completions while idle, then start spam while busy
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1 spur_done = 1'b1;
         @(posedge clk); #1 spur_done = 1'b0;
      end
      check("spur_idle_busy", 64'(busy), 64'd0);
      run_op("spam", 2, 3, 13, 8, CALLS_E3, 1'b1);

      // reset during the first square's wait, with a slow core
      lat = 40;
      drive_start(3, 4, 13);
      seen = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(posedge clk); #1;
         if (op_calls >= 2) begin
            seen = 1'b1;
            break;
         end
      end
      check("abort_reached_sq", 64'(seen), 64'd1);
      repeat (10) @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      check("abort_rst_result", 64'(result), 64'd0);
      check("abort_rst_busy", 64'(busy), 64'd0);
      check("abort_rst_mont_start", 64'(mont_start), 64'd0);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (resp_done) begin
            seen = 1'b1;
            break;
         end
      end
      check("late_done_seen", 64'(seen), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      check("late_done_busy", 64'(busy), 64'd0);
      check("late_done_done", 64'(done), 64'd0);
      check("late_done_result", 64'(result), 64'd0);
      check("late_done_mstart", 64'(mont_start), 64'd0);
      lat = 1;
      run_op("x3e4", 3, 4, 13, 3, CALLS_E4, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Initiator-side sequencer that drives the Montgomery multiplier core through its start/done handshake to compute X^E mod M.
- Uses left-to-right square-and-multiply in the Montgomery domain.
- Owns operand muxing, exponent bit scanning and the domain conversion in and out.
- Sits between the host register file and one montgomery core instance.

Parameters:
- WIDTH, 1024: modulus/operand width; must match the multiplier core.
- EW, 1024: exponent width in bits; the bit counter is $clog2(EW) bits wide.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; operands sampled on this cycle
- in_x  in  WIDTH  base X, X < M
- in_e  in  EW  exponent E
- in_m  in  WIDTH  odd modulus M
- in_r2  in  WIDTH  R^2 mod M, with R = 2^WIDTH
- in_rmodm  in  WIDTH  R mod M
- result  out  WIDTH  X^E mod M; held until the next accepted start
- done  out  1  one-cycle pulse, result valid in the same cycle
- busy  out  1  high from the cycle after an accepted start up to and including the done cycle
- mont_start  out  1  one-cycle pulse to the core
- mont_in_a  out  WIDTH  core operand A
- mont_in_b  out  WIDTH  core operand B
- mont_in_m  out  WIDTH  core modulus
- mont_result  in  WIDTH  core result
- mont_done  in  1  core completion pulse

Behaviour:
- Reset (asynchronous, resetn=0):
  - Outputs result=0, done=0, busy=0, mont_start=0.
  - FSM goes to IDLE.
  - Internal registers are cleared.
- Operand capture: on start in IDLE, latch X, E, M, R2, RmodM into local registers. Inputs may change afterwards. start while busy is ignored.
- Core handshake:
  - mont_start is asserted for exactly one cycle per call.
  - mont_in_a, mont_in_b and mont_in_m come from registers and are stable from the mont_start cycle until the cycle mont_done is seen.
  - mont_result is captured on the mont_done cycle.
  - The next call's mont_start is issued no earlier than the cycle after mont_done.
  - mont_done seen in a state that is not waiting for the core is ignored.
  - mont_in_m = latched M at all times after capture.
- FSM states:
  - IDLE -> CONV on start.
  - CONV: issue Mont(X, R2), wait, store Xt. Set A = RmodM. Set bit index i = EW-1. Go to SQ.
  - SQ: issue Mont(A, A), wait, A <= result. If E[i]=1 go to MUL, else go to NEXT.
  - MUL: issue Mont(A, Xt), wait, A <= result. Go to NEXT.
  - NEXT: if i == 0 go to POST, else i <= i-1 and go to SQ. This is one cycle with no core call.
  - POST: issue Mont(A, 1), wait, result <= core result. Go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Call count with the full scan: 1 + EW + popcount(E) + 1.
- E = 0: every SQ is skipped-multiply; result = Mont(RmodM, 1) = 1 mod M. This is not special-cased.
- Reset mid-operation: return immediately to IDLE. result is cleared. An in-flight core call is abandoned, and a mont_done arriving later is ignored.
- No arithmetic is performed locally. All modular operations go through the core.

Optional Feature:
- Macro: MODEXP_SKIP_LZ_EN.
- When defined: after CONV, i starts at the index of the most significant 1 of E, found by a priority encoder on the latched E. If E = 0, the FSM goes directly from CONV to POST with A = RmodM.
- When undefined: the full EW-bit scan applies; the cycle count is data-independent apart from multiplies.
- result is identical in both builds.

Test Plan:
- Bench uses a behavioural Montgomery responder returning a*b*R^-1 mod M after a configurable latency L (1, 5, 40 cycles).
- X=2, E=3, M=13 -> result=8, done pulses once. Core call count is 1028 without the macro and 6 with it.
- X=5, E=2, M=13 -> result=12. Check that mont_in_a and mont_in_b stay stable through every call.
- E=0, X=7, M=13 -> result=1. With the macro, exactly 2 core calls.
- start pulsed repeatedly while busy, plus spurious mont_done pulses while IDLE -> no effect; X=2, E=3 still gives result 8.
- resetn dropped during an SQ wait, then start with X=3, E=4, M=13 -> outputs are 0 during reset, the late mont_done is ignored, then result=3.
